// File: rtl/pipelined_mux_tree.sv
// pipelined_mux_tree: N-to-1 word mux built from registered 4:1 levels with valid/ready flow control
module pipelined_mux_tree #(
  parameter int WIDTH = 16,
  parameter int NUM_IN = 16,
  localparam int LEVELS = $clog2(NUM_IN) / 2,
  localparam int SEL_W = 2 * LEVELS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int NODES = (NUM_IN - 1) / 3;
  function automatic int base(input int k);
    int b = 0;
    for (int j = 0; j < k; j++) b += NUM_IN >> (2 * j + 2);
    return b;
  endfunction
  logic [WIDTH-1:0] node_d [NODES];
  logic [WIDTH-1:0] node_q [NODES];
  logic [SEL_W-1:0] sel_d [LEVELS];
  logic [SEL_W-1:0] sel_q [LEVELS];
  logic [LEVELS-1:0] vld_d, vld_q, rdy;
  always_comb begin
    rdy = '0;
    rdy[LEVELS-1] = !vld_q[LEVELS-1] || out_ready;
    for (int k = LEVELS - 2; k >= 0; k--) rdy[k] = !vld_q[k] || rdy[k+1];
    node_d = node_q;
    sel_d = sel_q;
    vld_d = vld_q;
    if (rdy[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        sel_d[0] = in_sel;
        for (int g = 0; g < NUM_IN / 4; g++)
          node_d[g] = in_data[(4 * g + int'(in_sel[1:0])) * WIDTH +: WIDTH];
      end
    end
    for (int k = 1; k < LEVELS; k++) begin
      if (rdy[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          sel_d[k] = sel_q[k-1];
          for (int g = 0; g < (NUM_IN >> (2 * k + 2)); g++)
            node_d[base(k) + g] = node_q[base(k - 1) + 4 * g + int'(sel_q[k-1][2*k +: 2])];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sel_q <= '{default: '0};
      node_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      sel_q <= sel_d;
      node_q <= node_d;
    end
  end
  assign in_ready = rdy[0];
  assign out_valid = vld_q[LEVELS-1];
  assign out_data = node_q[NODES-1];
  assign out_sel = sel_q[LEVELS-1];
endmodule

// File: tb/tb_pipelined_mux_tree.sv
// tb_pipelined_mux_tree: queue-model and directed checks for 16- and 64-channel trees
module tb_pipelined_mux_tree;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [16*16-1:0] d16;
  logic [3:0] sel16, os16;
  logic v16, r16, ov16, or16;
  logic [15:0] od16;
  logic [64*16-1:0] d64;
  logic [5:0] sel64, os64;
  logic v64, r64, ov64, or64;
  logic [15:0] od64;
  pipelined_mux_tree #(.WIDTH(16), .NUM_IN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(d16), .in_sel(sel16), .in_valid(v16), .in_ready(r16),
    .out_data(od16), .out_sel(os16), .out_valid(ov16), .out_ready(or16));
  pipelined_mux_tree #(.WIDTH(16), .NUM_IN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_data(d64), .in_sel(sel64), .in_valid(v64), .in_ready(r64),
    .out_data(od64), .out_sel(os64), .out_valid(ov64), .out_ready(or64));
  typedef struct { logic [15:0] d; logic [5:0] s; } item_t;
  item_t q16[$], q64[$];
  logic [15:0] got16[$], got64[$];
  int gcyc16[$], gcyc64[$], acc16[$], acc64[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Model: pipe contents are an in-order queue of words picked at acceptance; capacity equals tree depth
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      q16.delete();
      q64.delete();
    end else begin
      chk("in_ready16", 32'(r16), 32'((q16.size() < 2) || or16));
      if (ov16) begin
        if (q16.size() == 0) chk("spurious_out16", 32'(ov16), 32'(0));
        else begin
          chk("out_data16", 32'(od16), 32'(q16[0].d));
          chk("out_sel16", 32'(os16), 32'(q16[0].s));
        end
        if (or16) begin
          if (q16.size() != 0) void'(q16.pop_front());
          got16.push_back(od16);
          gcyc16.push_back(cyc);
        end
      end
      if (v16 && r16) begin
        it.d = d16[int'(sel16) * 16 +: 16];
        it.s = 6'(sel16);
        q16.push_back(it);
        acc16.push_back(cyc);
      end
      chk("in_ready64", 32'(r64), 32'((q64.size() < 3) || or64));
      if (ov64) begin
        if (q64.size() == 0) chk("spurious_out64", 32'(ov64), 32'(0));
        else begin
          chk("out_data64", 32'(od64), 32'(q64[0].d));
          chk("out_sel64", 32'(os64), 32'(q64[0].s));
        end
        if (or64) begin
          if (q64.size() != 0) void'(q64.pop_front());
          got64.push_back(od64);
          gcyc64.push_back(cyc);
        end
      end
      if (v64 && r64) begin
        it.d = d64[int'(sel64) * 16 +: 16];
        it.s = sel64;
        q64.push_back(it);
        acc64.push_back(cyc);
      end
    end
  end
  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    int lat, nxt;
    logic fire;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) d16[i*16 +: 16] = 16'hA000 + 16'(i);
    for (int i = 0; i < 64; i++) d64[i*16 +: 16] = 16'hA000 + 16'(i);
    v16 = 1'b1; sel16 = 4'd9; or16 = 1'b1;
    v64 = 1'b1; sel64 = 6'd9; or64 = 1'b1;
    repeat (3) step();
    chk("rst_out_valid16", 32'(ov16), 32'(0));
    chk("rst_out_data16", 32'(od16), 32'(0));
    chk("rst_out_sel16", 32'(os16), 32'(0));
    chk("rst_in_ready16", 32'(r16), 32'(1));
    chk("rst_out_valid64", 32'(ov64), 32'(0));
    chk("rst_in_ready64", 32'(r64), 32'(1));
    v16 = 1'b0; v64 = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    // latency, 16 channels
    sel16 = 4'd9; v16 = 1'b1;
    step();
    v16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 10) begin step(); lat++; end
    chk("latency16", 32'(lat), 32'(2));
    chk("lat_data16", 32'(od16), 32'h0000A009);
    chk("lat_sel16", 32'(os16), 32'd9);
    repeat (2) step();
    // streaming
    got16.delete(); gcyc16.delete(); acc16.delete();
    for (int i = 0; i < 16; i++) begin
      sel16 = 4'(i); v16 = 1'b1;
      step();
    end
    v16 = 1'b0;
    repeat (4) step();
    chk("stream_count16", 32'(got16.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got16.size()) begin
        chk("stream_data16", 32'(got16[i]), 32'(16'hA000 + 16'(i)));
        chk("stream_cycle16", 32'(gcyc16[i]), 32'(acc16[0] + 2 + i));
      end
    // backpressure mid-stream
    got16.delete();
    nxt = 0;
    v16 = 1'b1;
    for (int t = 0; t < 40 && nxt < 12; t++) begin
      or16 = !(t >= 4 && t <= 8);
      sel16 = 4'(nxt);
      @(negedge clk);
      fire = r16;
      if (t >= 4 && t <= 8) begin
        chk("bp_in_ready", 32'(r16), 32'(0));
        chk("bp_hold_data", 32'(od16), 32'h0000A002);
      end
      @(posedge clk);
      #1;
      if (fire) nxt++;
    end
    v16 = 1'b0; or16 = 1'b1;
    repeat (5) step();
    chk("bp_count", 32'(got16.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      if (i < got16.size()) chk("bp_data", 32'(got16[i]), 32'(16'hA000 + 16'(i)));
    // bubble: valid 1,0,1 while stalled
    got16.delete(); gcyc16.delete();
    or16 = 1'b0;
    sel16 = 4'd5; v16 = 1'b1; step();
    v16 = 1'b0; step();
    sel16 = 4'd6; v16 = 1'b1; step();
    v16 = 1'b0;
    chk("bubble_in_ready", 32'(r16), 32'(0));
    chk("bubble_out_valid", 32'(ov16), 32'(1));
    repeat (3) step();
    chk("bubble_hold", 32'(od16), 32'h0000A005);
    or16 = 1'b1;
    repeat (4) step();
    chk("bubble_count", 32'(got16.size()), 32'd2);
    if (got16.size() == 2) begin
      chk("bubble_first", 32'(got16[0]), 32'h0000A005);
      chk("bubble_second", 32'(got16[1]), 32'h0000A006);
      chk("bubble_consecutive", 32'(gcyc16[1]), 32'(gcyc16[0] + 1));
    end
    // reset with two words queued
    got16.delete();
    or16 = 1'b0;
    sel16 = 4'd1; v16 = 1'b1; step();
    sel16 = 4'd2; step();
    v16 = 1'b0;
    chk("pre_reset_valid", 32'(ov16), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ov16), 32'(0));
    chk("async_rst_data", 32'(od16), 32'(0));
    repeat (2) step();
    rst_n = 1'b1;
    or16 = 1'b1;
    sel16 = 4'd3; v16 = 1'b1; step();
    v16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 10) begin step(); lat++; end
    chk("post_rst_latency", 32'(lat), 32'(2));
    chk("post_rst_data", 32'(od16), 32'h0000A003);
    chk("post_rst_sel", 32'(os16), 32'd3);
    repeat (3) step();
    chk("post_rst_count", 32'(got16.size()), 32'd1);
    // latency, 64 channels
    sel64 = 6'd9; v64 = 1'b1;
    step();
    v64 = 1'b0;
    lat = 1;
    while (!ov64 && lat < 10) begin step(); lat++; end
    chk("latency64", 32'(lat), 32'(3));
    chk("lat_data64", 32'(od64), 32'h0000A009);
    chk("lat_sel64", 32'(os64), 32'd9);
    repeat (2) step();
    // streaming over scattered selects, 64 channels
    got64.delete(); gcyc64.delete(); acc64.delete();
    for (int i = 0; i < 16; i++) begin
      sel64 = 6'((i * 13) % 64); v64 = 1'b1;
      step();
    end
    v64 = 1'b0;
    repeat (5) step();
    chk("stream_count64", 32'(got64.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got64.size()) begin
        chk("stream_data64", 32'(got64[i]), 32'(16'hA000 + 16'((i * 13) % 64)));
        chk("stream_cycle64", 32'(gcyc64[i]), 32'(acc64[0] + 3 + i));
      end
    // short stall on the 64-channel tree
    got64.delete();
    or64 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel64 = 6'(63 - i); v64 = 1'b1;
      step();
    end
    v64 = 1'b0;
    chk("stall64_in_ready", 32'(r64), 32'(0));
    chk("stall64_hold", 32'(od64), 32'h0000A03F);
    or64 = 1'b1;
    repeat (5) step();
    chk("stall64_count", 32'(got64.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got64.size()) chk("stall64_data", 32'(got64[i]), 32'(16'hA03F - 16'(i)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
